// File: rtl/hazard_mem_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / data-memory sequencing controller.
package hazard_mem_ctrl_pkg;

  // Forwarding select encodings for the EX-stage operand muxes.
  localparam logic [1:0] FWD_RF = 2'b00;  // operand from the register file
  localparam logic [1:0] FWD_W  = 2'b01;  // operand from ResultW
  localparam logic [1:0] FWD_M  = 2'b10;  // operand from ALUResultM

  // Data-memory handshake states.
  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_WAIT = 2'd1,
    MS_HALT = 2'd2
  } memState_t;

  // Forwarding select for one EX source register; M outranks W and x0 never forwards.
  function automatic logic [1:0] fwdSelect(
    input logic [4:0] rsE,
    input logic [4:0] rdM,
    input logic       regWriteM,
    input logic [4:0] rdW,
    input logic       regWriteW
  );
    if (regWriteM && (rdM != 5'd0) && (rdM == rsE)) begin
      return FWD_M;
    end else if (regWriteW && (rdW != 5'd0) && (rdW == rsE)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_mem_ctrl_mem_wait_fsm.sv
// Valid/ready handshake with the data memory: holds the request while the
// memory is not ready and gives up (sticky halt) after MEM_TIMEOUT stalled cycles.
module mem_wait_fsm
  import hazard_mem_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic memAccess,
  input  logic memReady,
  output logic memValid,
  output logic memStall,
  output logic halted
);

  // Counter only has to reach MEM_TIMEOUT-1.
  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_TIMEOUT - 1);

  memState_t      state;
  memState_t      nextState;
  logic [CW-1:0]  waitCnt;
  logic [CW-1:0]  nextCnt;

  // State and wait-counter registers.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state   <= MS_IDLE;
      waitCnt <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= nextCnt;
    end
  end

  // Next-state, counter update and handshake outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    nextState = state;
    nextCnt   = waitCnt;
    memValid  = 1'b0;
    memStall  = 1'b0;
    unique case (state)
      MS_IDLE: begin
        memValid = memAccess;
        memStall = memAccess & ~memReady;
        if (memStall) begin
          nextState = MS_WAIT;
          nextCnt   = CW'(1);
        end
      end
      MS_WAIT: begin
        memValid = 1'b1;
        memStall = ~memReady;
        if (memReady) begin
          nextState = MS_IDLE;
          nextCnt   = '0;
        end else if (waitCnt == LAST_WAIT) begin
          nextState = MS_HALT;
        end else begin
          nextCnt = waitCnt + CW'(1);
        end
      end
      MS_HALT: begin
        memStall = 1'b1;
      end
      default: begin
        nextState = MS_IDLE;
        nextCnt   = '0;
      end
    endcase
  end

  assign halted = (state == MS_HALT);

endmodule

// File: rtl/hazard_mem_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: forwarding selects,
// load-use and branch handling, memory-wait freezing and a stall-cycle counter.
module hazard_mem_ctrl
  import hazard_mem_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic             MemAccessM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  input  logic             MemReady,
  output logic             MemValid,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             EnableW,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             Halted,
  output logic [CNT_W-1:0] StallCycles
);

  logic memStall;
  logic memValidRaw;
  logic lwStall;

  mem_wait_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) uMemWait (
    .clock     (clock),
    .reset     (reset),
    .memAccess (MemAccessM),
    .memReady  (MemReady),
    .memValid  (memValidRaw),
    .memStall  (memStall),
    .halted    (Halted)
  );

  // A load in E whose destination feeds an instruction in D must hold D for one cycle.
  assign lwStall = ResultSrcE0 & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

  // Pipeline controls; a memory freeze overrides branch and load-use handling, and
  // reset forces a safe flushed pipeline without waiting for a clock edge.
  always_comb begin
    MemValid  = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    EnableW   = 1'b1;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (reset) begin
      MemValid  = memValidRaw;
      ForwardAE = fwdSelect(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwdSelect(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      if (memStall) begin
        // E is frozen, so PCSrcE and lwStall are re-evaluated after release.
        StallF  = 1'b1;
        StallD  = 1'b1;
        StallE  = 1'b1;
        StallM  = 1'b1;
        EnableW = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
      end else begin
        StallF = lwStall;
        StallD = lwStall;
        FlushD = PCSrcE;
        FlushE = lwStall | PCSrcE;
      end
    end
  end

  // Saturating count of cycles in which fetch was held.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      StallCycles <= '0;
    end else if (StallF && (StallCycles != '1)) begin
      StallCycles <= StallCycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_mem_ctrl.sv
// Self-checking bench: a cycle-level behavioural model checked on every falling
// edge, plus directed scenarios with hand-computed literal expectations.
module tb_hazard_mem_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = 15;

  logic             clock;
  logic             reset;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             ResultSrcE0, PCSrcE, RegWriteM, MemAccessM, RegWriteW, MemReady;
  logic             MemValid, StallF, StallD, StallE, StallM, EnableW, FlushD, FlushE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             Halted;
  logic [CNT_W-1:0] StallCycles;

  int errors = 0;
  int checks = 0;

  hazard_mem_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .Rs1D        (Rs1D),
    .Rs2D        (Rs2D),
    .Rs1E        (Rs1E),
    .Rs2E        (Rs2E),
    .RdE         (RdE),
    .ResultSrcE0 (ResultSrcE0),
    .PCSrcE      (PCSrcE),
    .RdM         (RdM),
    .RegWriteM   (RegWriteM),
    .MemAccessM  (MemAccessM),
    .RdW         (RdW),
    .RegWriteW   (RegWriteW),
    .MemReady    (MemReady),
    .MemValid    (MemValid),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallM      (StallM),
    .EnableW     (EnableW),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .Halted      (Halted),
    .StallCycles (StallCycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An access is "outstanding" once it has been stalled at least one cycle;
  // after MEM_TIMEOUT consecutive stalled cycles the controller is halted for good.
  logic mInAccess, mHalted;
  int   mWaited, mCnt;
  logic nMemStall, nStallF;

  function automatic logic [1:0] modelFwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mInAccess <= 1'b0;
      mHalted   <= 1'b0;
      mWaited   <= 0;
      mCnt      <= 0;
    end else begin
      if (!mHalted) begin
        if (nMemStall) begin
          if (mWaited + 1 >= MEM_TIMEOUT) mHalted <= 1'b1;
          else mInAccess <= 1'b1;
          mWaited <= mWaited + 1;
        end else begin
          mInAccess <= 1'b0;
          mWaited   <= 0;
        end
      end
      if (nStallF && mCnt < CNT_MAX) mCnt <= mCnt + 1;
    end
  end

  logic       eValid, eMem, eLw, eSF, eSE, eEnW, eFD, eFE;
  logic [1:0] eFA, eFB;

  always @(negedge clock) begin
    if (!reset) begin
      eValid = 0; eMem = 0; eSF = 0; eSE = 0; eEnW = 1; eFD = 1; eFE = 1;
      eFA = 2'b00; eFB = 2'b00;
    end else begin
      if (mHalted) begin
        eValid = 0; eMem = 1;
      end else if (mInAccess) begin
        eValid = 1; eMem = !MemReady;
      end else begin
        eValid = MemAccessM; eMem = MemAccessM && !MemReady;
      end
      eLw = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      eFA = modelFwd(Rs1E);
      eFB = modelFwd(Rs2E);
      if (eMem) begin
        eSF = 1; eSE = 1; eEnW = 0; eFD = 0; eFE = 0;
      end else begin
        eSF = eLw; eSE = 0; eEnW = 1; eFD = PCSrcE; eFE = eLw || PCSrcE;
      end
    end
    check("cyc_MemValid", MemValid, eValid);
    check("cyc_StallF", StallF, eSF);
    check("cyc_StallD", StallD, eSF);
    check("cyc_StallE", StallE, eSE);
    check("cyc_StallM", StallM, eSE);
    check("cyc_EnableW", EnableW, eEnW);
    check("cyc_FlushD", FlushD, eFD);
    check("cyc_FlushE", FlushE, eFE);
    check("cyc_ForwardAE", ForwardAE, eFA);
    check("cyc_ForwardBE", ForwardBE, eFB);
    check("cyc_Halted", Halted, reset ? mHalted : 1'b0);
    check("cyc_StallCycles", StallCycles, reset ? mCnt : 0);
    nMemStall <= reset ? eMem : 1'b0;
    nStallF   <= reset ? eSF : 1'b0;
  end

  // ---------------- directed stimulus ----------------
  task automatic clearInputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE0 = 0; PCSrcE = 0; RegWriteM = 0; MemAccessM = 0; RegWriteW = 0; MemReady = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    clearInputs();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    clearInputs();
    // Outputs forced while reset is held, even with live requests present.
    MemAccessM = 1; RegWriteM = 1; RdM = 5; Rs1E = 5;
    #2;
    check("rst_MemValid", MemValid, 0);
    check("rst_ForwardAE", ForwardAE, 2'b00);
    check("rst_FlushD", FlushD, 1);
    check("rst_FlushE", FlushE, 1);
    check("rst_EnableW", EnableW, 1);
    check("rst_StallF", StallF, 0);
    check("rst_StallCycles", StallCycles, 0);
    check("rst_Halted", Halted, 0);
    clearInputs();
    tick();
    reset = 1'b1;

    // Forwarding: M beats W, W alone, x0 never forwarded.
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
    #1 check("fwd_M_priority", ForwardAE, 2'b10);
    tick();
    RegWriteM = 0;
    #1 check("fwd_W_only", ForwardAE, 2'b01);
    tick();
    RegWriteM = 1; Rs1E = 0; RdM = 0; RdW = 0;
    #1 check("fwd_x0", ForwardAE, 2'b00);
    tick();
    RdM = 7; RdW = 9; Rs2E = 9; Rs1E = 7;
    #1 check("fwd_B_W", ForwardBE, 2'b01);
    check("fwd_A_M", ForwardAE, 2'b10);
    tick();

    // Load-use: one-cycle stall, counter 0 -> 1.
    doReset();
    ResultSrcE0 = 1; RdE = 3; Rs2D = 3;
    #1 check("lu_StallF", StallF, 1);
    check("lu_StallD", StallD, 1);
    check("lu_FlushE", FlushE, 1);
    check("lu_FlushD", FlushD, 0);
    check("lu_cnt_before", StallCycles, 0);
    tick();
    ResultSrcE0 = 0;
    #1 check("lu_StallF_after", StallF, 0);
    check("lu_cnt_after", StallCycles, 1);
    tick();
    ResultSrcE0 = 1; RdE = 0; Rs1D = 0; Rs2D = 0;
    #1 check("lu_rd0_nostall", StallF, 0);
    tick();
    // Load-use together with a taken branch.
    RdE = 4; Rs1D = 4; PCSrcE = 1;
    #1 check("lubr_FlushD", FlushD, 1);
    check("lubr_FlushE", FlushE, 1);
    check("lubr_StallF", StallF, 1);
    tick();

    // Memory wait: three not-ready cycles, release on the fourth, branch held back.
    doReset();
    MemAccessM = 1; MemReady = 0; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check("mw_MemValid", MemValid, 1);
      check("mw_StallM", StallM, 1);
      check("mw_EnableW", EnableW, 0);
      check("mw_FlushD", FlushD, 0);
      tick();
    end
    MemReady = 1;
    #1 check("mw_rel_MemValid", MemValid, 1);
    check("mw_rel_StallF", StallF, 0);
    check("mw_rel_EnableW", EnableW, 1);
    check("mw_rel_FlushD", FlushD, 1);
    check("mw_rel_FlushE", FlushE, 1);
    tick();
    PCSrcE = 0;
    #1 check("mw_b2b_MemValid", MemValid, 1);
    check("mw_b2b_StallE", StallE, 0);
    tick();
    MemAccessM = 0;
    #1 check("mw_ready_ignored", MemValid, 0);
    check("mw_cnt", StallCycles, 3);
    tick();

    // Timeout: HALT on the 4th edge, then held; counter saturates.
    doReset();
    MemAccessM = 1; MemReady = 0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      #1 check("to_pre_Halted", Halted, 0);
      tick();
    end
    #1 check("to_Halted", Halted, 1);
    check("to_MemValid", MemValid, 0);
    check("to_StallM", StallM, 1);
    for (int i = 0; i < 20; i++) begin
      MemReady = i[0];
      tick();
    end
    #1 check("to_hold_Halted", Halted, 1);
    check("to_hold_StallF", StallF, 1);
    check("to_hold_cnt", StallCycles, CNT_MAX);

    // Async reset mid-cycle while halted.
    reset = 1'b0;
    #1 check("ar_Halted", Halted, 0);
    check("ar_cnt", StallCycles, 0);
    check("ar_MemValid", MemValid, 0);
    check("ar_FlushE", FlushE, 1);
    tick();
    reset = 1'b1; MemReady = 1;
    #1 check("ar_idle_MemValid", MemValid, 1);
    check("ar_idle_StallF", StallF, 0);
    tick();

    // Saturation under a continuous load-use stall.
    doReset();
    ResultSrcE0 = 1; RdE = 3; Rs1D = 3;
    repeat (20) tick();
    check("sat_cnt", StallCycles, CNT_MAX);
    check("sat_StallF", StallF, 1);
    clearInputs();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
